// File: rtl/bit_serial_adder.sv
// bit_serial_adder: adds two WIDTH-bit operands one bit per cycle through a single shared full adder
// Ports: clk/rst (sync, active-high); in_valid/in_ready take a, b, cin in IDLE;
//        sum/cout/ovf are registered results qualified by out_valid/out_ready in DONE.

module FULL_ADDER (
   input  logic in0,
   input  logic in1,
   input  logic in2,
   output logic out,
   output logic cout
);
   assign out  = in0 ^ in1 ^ in2;
   assign cout = (in0 & in1) | (in2 & (in0 ^ in1));
endmodule

module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_ovf;
   logic             w_s, w_co, w_last;
   FULL_ADDER u_fa (
      .in0  (r_a[0]),
      .in1  (r_b[0]),
      .in2  (r_carry),
      .out  (w_s),
      .cout (w_co)
   );
   assign w_last = r_cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb
      w_next = (r_state == IDLE) ? (in_valid  ? RUN  : IDLE) :
               (r_state == RUN)  ? (w_last    ? DONE : RUN)  :
                                   (out_ready ? IDLE : DONE);
   always_comb begin
      in_ready  = r_state == IDLE;
      out_valid = r_state == DONE;
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == IDLE && in_valid) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         // sum fills from the MSB end so bit 0 lands at position 0 after WIDTH shifts
         r_sum   <= WIDTH'({w_s, r_sum} >> 1);
         r_carry <= w_co;
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) r_ovf <= r_carry ^ w_co;
      end
   assign sum  = r_sum;
   assign cout = r_carry;
   assign ovf  = r_ovf;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed vectors, corner sequences and random ops for bit_serial_adder
module tb_bit_serial_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   logic iv, ir, ov, orr, ci, co, of;
   logic [7:0] a, b, s;
   logic iv1, ir1, ov1, or1, ci1, co1, of1;
   logic [0:0] a1, b1, s1;
   logic iv16, ir16, ov16, or16, ci16, co16, of16;
   logic [15:0] a16, b16, s16;
   int checks = 0, errors = 0;

   bit_serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci),
      .sum(s), .cout(co), .ovf(of), .out_valid(ov), .out_ready(orr));
   bit_serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1),
      .sum(s1), .cout(co1), .ovf(of1), .out_valid(ov1), .out_ready(or1));
   bit_serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(ci16),
      .sum(s16), .cout(co16), .ovf(of16), .out_valid(ov16), .out_ready(or16));

   typedef struct {
      logic [7:0] a, b;
      logic       cin;
      logic [7:0] sum;
      logic       cout, ovf;
   } vec_t;
   vec_t vt[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Issues one 8-bit op and returns once out_valid is seen (or the bound expires).
   task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      output logic [7:0] rs, output logic rc, output logic ro, output int lat);
      int n;
      a = xa; b = xb; ci = xc; iv = 1'b1;
      n = 0;
      while (!ir && n < 50) begin step; n++; end
      step;
      iv = 1'b0;
      lat = 0;
      while (!ov && lat < 50) begin step; lat++; end
      rs = s; rc = co; ro = of;
   endtask

   logic [7:0] rs;
   logic       rc, ro;
   int         lat;
   logic       seen;

   initial begin
      vt[0] = '{8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1};
      vt[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vt[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
      vt[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vt[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vt[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
      vt[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
      rst = 1'b1; iv = 0; orr = 1; a = 0; b = 0; ci = 0;
      iv1 = 0; or1 = 0; a1 = 0; b1 = 0; ci1 = 0;
      iv16 = 0; or16 = 0; a16 = 0; b16 = 0; ci16 = 0;
      step; step;
      rst = 1'b0;
      step; step; step;
      chk("reset_in_ready", ir, 1);
      chk("reset_out_valid", ov, 0);
      chk("reset_sum", s, 0);
      chk("reset_cout", co, 0);
      chk("reset_ovf", of, 0);

      for (int i = 0; i < 9; i++) begin
         op8(vt[i].a, vt[i].b, vt[i].cin, rs, rc, ro, lat);
         chk($sformatf("vec%0d_sum", i), rs, vt[i].sum);
         chk($sformatf("vec%0d_cout", i), rc, vt[i].cout);
         chk($sformatf("vec%0d_ovf", i), ro, vt[i].ovf);
         chk($sformatf("vec%0d_latency", i), lat + 1, 9);
         step;
         chk($sformatf("vec%0d_valid_drop", i), ov, 0);
         chk($sformatf("vec%0d_ready_back", i), ir, 1);
      end

      // backpressure: result held, pulsed request ignored
      orr = 1'b0;
      op8(8'h3C, 8'h55, 1'b0, rs, rc, ro, lat);
      chk("bp_sum", rs, 8'h91);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin a = 8'h11; b = 8'h22; ci = 1'b1; iv = 1'b1; end
         if (i == 6) iv = 1'b0;
         step;
         chk($sformatf("bp_hold%0d", i), {ov, ir, co, of, s}, {1'b1, 1'b0, 1'b0, 1'b1, 8'h91});
      end
      orr = 1'b1;
      step;
      chk("bp_consume", {ov, ir}, 2'b01);
      for (int i = 0; i < 12; i++) step;
      chk("bp_no_queue", {ov, ir}, 2'b01);

      // reset in the middle of RUN
      a = 8'hAA; b = 8'h55; ci = 1'b0; iv = 1'b1;
      step;
      iv = 1'b0;
      for (int i = 0; i < 4; i++) step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk("midrst_in_ready", ir, 1);
      chk("midrst_out_valid", ov, 0);
      chk("midrst_sum", s, 0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin step; seen |= ov; end
      chk("midrst_no_result", seen, 0);
      op8(8'h01, 8'h01, 1'b0, rs, rc, ro, lat);
      chk("midrst_next_sum", rs, 8'h02);
      step;

      fork
         begin : rnd16
            logic [16:0] full;
            int n;
            for (int i = 0; i < 1000; i++) begin
               a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
               full = {1'b0, a16} + {1'b0, b16} + 17'(ci16);
               iv16 = 1'b1;
               n = 0;
               while (!ir16 && n < 100) begin step; n++; end
               step;
               iv16 = 1'b0;
               or16 = 1'($urandom);
               n = 0;
               while (!(ov16 && or16) && n < 200) begin
                  chk("w16_handshake_excl", ir16 & ov16, 0);
                  step;
                  or16 = 1'($urandom);
                  n++;
               end
               chk($sformatf("w16_op%0d", i), {ov16, co16, of16, s16},
                   {1'b1, full[16], (a16[15] == b16[15]) && (full[15] != a16[15]), full[15:0]});
               step;
            end
            or16 = 1'b0;
         end
         begin : rnd1
            logic [1:0] full;
            int n;
            for (int i = 0; i < 1000; i++) begin
               a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
               full = {1'b0, a1} + {1'b0, b1} + 2'(ci1);
               iv1 = 1'b1;
               n = 0;
               while (!ir1 && n < 100) begin step; n++; end
               step;
               iv1 = 1'b0;
               or1 = 1'($urandom);
               n = 0;
               while (!(ov1 && or1) && n < 200) begin
                  chk("w1_handshake_excl", ir1 & ov1, 0);
                  step;
                  or1 = 1'($urandom);
                  n++;
               end
               chk($sformatf("w1_op%0d", i), {ov1, co1, of1, s1},
                   {1'b1, full[1], (a1 == b1) && (full[0] != a1[0]), full[0]});
               step;
            end
            or1 = 1'b0;
         end
      join

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
